// File: rtl/err_display_if.sv
// Interface between the error/status logic and the err_display_scan display driver.
// The error side uses the master modport; the display driver uses the slave modport.
interface err_display_if #(
   parameter int NUM_DIGITS = 4,
   parameter int NUM_ERR    = 3
);
   logic [NUM_ERR-1:0]    err_in;
   logic                  err_clr;
   logic [3:0]            select;
   logic [NUM_DIGITS-1:0] digitos;
   logic [6:0]            segmentos;
   logic                  err_any;

   modport master (
      output err_in, err_clr, select,
      input  digitos, segmentos, err_any
   );

   modport slave (
      input  err_in, err_clr, select,
      output digitos, segmentos, err_any
   );
endinterface

// File: rtl/err_display_scan.sv
// Time-multiplexed 7-segment driver showing "Err" plus a one-digit code of the selected latched error.
// Optional feature: define ERR_BLINK_EN to blink the segments every BLINK_FRAMES scan frames.
module err_display_scan #(
   parameter int NUM_DIGITS   = 4,
   parameter int NUM_ERR      = 3,
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic         clk0,
   input  logic         reset,
   err_display_if.slave bus
);
   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_R     = 7'b0101111;

   if (NUM_DIGITS < 4 || NUM_DIGITS > 8 || NUM_ERR < 1 || NUM_ERR > 9 ||
       SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_params
      $error("err_display_scan: parameter out of legal range");
   end

   logic [NUM_ERR-1:0] lat;
   logic [PRE_W-1:0]   presc;
   logic [IDX_W-1:0]   idx;
   logic [3:0]         code;
   logic [3:0]         next_code;
   logic [3:0]         auto_code;
   logic [3:0]         sel_code;
   logic [6:0]         glyph;
   logic               seg_on;
   logic               pre_tc;
   logic               frame_wrap;

   function automatic logic [6:0] digit_glyph(input logic [3:0] c);
      case (c)
         4'd1:    digit_glyph = 7'b1111001;
         4'd2:    digit_glyph = 7'b0100100;
         4'd3:    digit_glyph = 7'b0110000;
         4'd4:    digit_glyph = 7'b0011001;
         4'd5:    digit_glyph = 7'b0010010;
         4'd6:    digit_glyph = 7'b0000010;
         4'd7:    digit_glyph = 7'b1111000;
         4'd8:    digit_glyph = 7'b0000000;
         4'd9:    digit_glyph = 7'b0010000;
         default: digit_glyph = SEG_BLANK;
      endcase
   endfunction

   assign pre_tc     = (presc == PRE_W'(SCAN_DIV - 1));
   assign frame_wrap = pre_tc && (idx == IDX_W'(NUM_DIGITS - 1));

   // Code the next frame would show; only sampled at the frame wrap.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      auto_code = '0;
      sel_code  = '0;
      for (int i = NUM_ERR - 1; i >= 0; i--) begin
         if (lat[i]) auto_code = 4'(i + 1);
      end
      for (int i = 0; i < NUM_ERR; i++) begin
         if (bus.select == 4'(i + 1) && lat[i]) sel_code = 4'(i + 1);
      end
      next_code = (bus.select == 4'd0) ? auto_code : sel_code;
   end

   always_comb begin
      glyph = SEG_BLANK;
      if (code != 4'd0) begin
         if (idx == IDX_W'(NUM_DIGITS - 1))
            glyph = SEG_E;
         else if (idx == IDX_W'(NUM_DIGITS - 2) || idx == IDX_W'(NUM_DIGITS - 3))
            glyph = SEG_R;
         else if (idx == '0)
            glyph = digit_glyph(code);
      end
   end

   always_ff @(posedge clk0 or posedge reset) begin
      if (reset) begin
         lat           <= '0;
         presc         <= '0;
         idx           <= '0;
         code          <= '0;
         bus.err_any   <= 1'b0;
         bus.digitos   <= '1;
         bus.segmentos <= SEG_BLANK;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
         lat         <= bus.err_clr ? bus.err_in : (lat | bus.err_in);
         bus.err_any <= |lat;
         if (pre_tc) begin
            presc <= '0;
            idx   <= frame_wrap ? '0 : idx + IDX_W'(1);
         end else begin
            presc <= presc + PRE_W'(1);
         end
         // Capturing once per frame keeps the whole frame consistent (no tearing).
         if (frame_wrap) code <= next_code;
         bus.digitos   <= ~(NUM_DIGITS'(1) << idx);
         bus.segmentos <= seg_on ? glyph : SEG_BLANK;
      end
   end

`ifdef ERR_BLINK_EN
   localparam int FR_W = $clog2(BLINK_FRAMES + 1);
   logic [FR_W-1:0] frame_cnt;
   logic            phase_on;

   always_ff @(posedge clk0 or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
         phase_on  <= 1'b1;
      end else if (frame_wrap) begin
         // A freshly appearing error always starts in the visible phase.
         if (code == 4'd0 && next_code != 4'd0) begin
            frame_cnt <= '0;
            phase_on  <= 1'b1;
         end else if (frame_cnt == FR_W'(BLINK_FRAMES - 1)) begin
            frame_cnt <= '0;
            phase_on  <= ~phase_on;
         end else begin
            frame_cnt <= frame_cnt + FR_W'(1);
         end
      end
   end

   assign seg_on = phase_on;
`else
   assign seg_on = 1'b1;
`endif
endmodule

// File: doc/err_display_scan.md
Name: err_display_scan

Overview:
- Parametrised, time-multiplexed 7-segment error display driver.
- Latches error flags from NUM_ERR sources (sticky until cleared) and picks one source, either by priority or by the select input.
- Scans NUM_DIGITS common digits and shows "Err" followed by a one-digit error code.
- Sits between the error/status logic and the board's 7-segment display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal range 4..8.
- NUM_ERR, 3, number of error sources; legal range 1..9.
- SCAN_DIV, 50000, clk0 cycles each digit stays enabled; must be >= 2.
- BLINK_FRAMES, 64, full scan frames per blink half-period. Used only when ERR_BLINK_EN is defined.

Ports:
- clk0  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- err_in  in  NUM_ERR  raw error flags, active-high; bit 0 has the highest priority.
- err_clr  in  1  synchronous clear of all latched errors.
- select  in  4  0 = auto (highest-priority active error); k in 1..NUM_ERR = show source k-1 only.
- digitos  out  NUM_DIGITS  digit enables, active-low, one-hot-low while scanning.
- segmentos  out  7  segments {g,f,e,d,c,b,a}, active-low.
- err_any  out  1  OR of the latched errors.

Behaviour:
- Reset (async assert, sync release):
  - digitos = all 1.
  - segmentos = 7'b1111111.
  - err_any = 0.
  - Latched errors, prescaler, digit index and frame code are all cleared to 0.
- Error latch, every cycle: lat <= err_clr ? err_in : (lat | err_in).
  - If err_clr and err_in are both high, set wins for the bits that are high in err_in.
  - err_any = |lat, registered. A high on err_in at edge t shows on err_any after edge t+1.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - At terminal count it wraps to 0 and the digit index advances; the index wraps from NUM_DIGITS-1 to 0.
- Frame code capture (anti-tearing):
  - The code is captured only on the cycle the index wraps to 0. It holds for the whole frame.
  - Auto mode (select=0): code = lowest-index set bit of lat, plus 1. If no bit is set, code = 0, meaning blank frame.
  - select=k with 1<=k<=NUM_ERR: code = k if lat[k-1] is set, else 0.
  - select > NUM_ERR: code = 0.
- Glyph map by digit position:
  - NUM_DIGITS-1 = 'E' (0000110).
  - NUM_DIGITS-2 = 'r' (0101111).
  - NUM_DIGITS-3 = 'r' (0101111).
  - Position 0 = decimal code digit: '1' = 1111001, '2' = 0100100, '3' = 0110000, '4' = 0011001, '5' = 0010010, '6' = 0000010, '7' = 1111000, '8' = 0000000, '9' = 0010000.
  - Any other position = blank.
- With code = 0, every position shows blank (1111111).
- Outputs are registered:
  - digitos drives a 0 at the current index.
  - segmentos drives the glyph for that index.
  - Both change on the same edge, one cycle after the index changes.
- Reset asserted mid-frame: outputs go to the reset values immediately. The scan restarts at index 0 with code 0; the first capture happens at the first wrap after release.

Optional Feature:
- Macro: ERR_BLINK_EN.
- Defined:
  - A frame counter toggles a blink phase every BLINK_FRAMES frames.
  - In the off phase, segmentos is forced to 1111111; the digitos scan continues unchanged.
  - The phase resets to "on" at reset and whenever the captured code changes from 0 to non-zero.
- Undefined:
  - No blink logic is present; the display is steady.

Test Plan (SCAN_DIV=4, NUM_DIGITS=4, NUM_ERR=3, BLINK_FRAMES=2):
1. Hold reset, then release with err_in=0 -> digitos=1111 for one cycle, then scans 1110, 1101, 1011, 0111 (4 cycles each); segmentos stays 1111111; err_any=0.
2. err_in=3'b110 pulse for 1 cycle, select=0 -> err_any=1 from the next cycle. From the next frame: digit3=0000110, digit2=0101111, digit1=0101111, digit0=0100100 ('2').
3. lat=3'b110, then select=1 -> next frame is fully blank. select=3 -> digit0=0110000 ('3'). select=9 -> blank.
4. err_clr=1 together with err_in=3'b001 -> lat=3'b001. Next frame shows code '1' (1111001).
5. err_in toggled mid-frame -> segmentos for digit0 is unchanged until the index wraps to 0.
6. ERR_BLINK_EN defined, error active -> segmentos is non-blank for 2 frames, then 1111111 for 2 frames, repeating; digitos keeps scanning throughout.
